// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flip-flop.
// Operands are shifted through LSB first, one bit per clock, with a
// start/busy/done handshake. The result holds until the next accepted start.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sh_a, sh_a_next;
    logic [WIDTH-1:0] sh_b, sh_b_next;
    logic             carry, carry_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [WIDTH-1:0] sum_next;
    logic             cout_next;
    logic             busy_next;
    logic             done_next;
    logic             s_bit;
    logic             c_bit;

    // The single full-adder cell working on the current low bits.
    always_comb begin
        s_bit = sh_a[0] ^ sh_b[0] ^ carry;
        c_bit = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
    end

    // Next-state and next-output logic; start is honoured only in IDLE or DONE.
    always_comb begin
        state_next = state;
        sh_a_next  = sh_a;
        sh_b_next  = sh_b;
        carry_next = carry;
        cnt_next   = cnt;
        sum_next   = sum;
        cout_next  = cout;
        busy_next  = busy;
        done_next  = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    sh_a_next  = a;
                    sh_b_next  = b;
                    carry_next = cin;
                    cnt_next   = '0;
                    sum_next   = '0;
                    cout_next  = 1'b0;
                    busy_next  = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                carry_next = c_bit;
                sum_next   = {s_bit, sum[WIDTH-1:1]};
                sh_a_next  = {1'b0, sh_a[WIDTH-1:1]};
                sh_b_next  = {1'b0, sh_b[WIDTH-1:1]};
                cnt_next   = cnt + 1'b1;
                if (cnt == LAST) begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    cout_next  = c_bit;
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset wipes any partial result at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            sh_a  <= sh_a_next;
            sh_b  <= sh_b_next;
            carry <= carry_next;
            cnt   <= cnt_next;
            sum   <= sum_next;
            cout  <= cout_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

endmodule
